sf_access_arb: RTL and testbench

Sequences all accesses to the HN-F snoop-filter tag/state/RNF-vector arrays. Two requesters share one single-ported array: POCQ head lookups and SF update writes, for example from CompAck or snoop-response handling. Grants one access at a time with update priority and bounded lookup starvation. Runs the registered read, compares the tag, and returns hit/state/vector to the POCQ.

---
 rtl/sf_access_arb.sv | 139 +++++++++++++
 tb/tb_sf_access_arb.sv | 381 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sf_access_arb.sv
// Snoop-filter array access sequencer: arbitrates POCQ lookups against SF updates
// on a single-ported tag/state/vector array and returns registered lookup results.
module sf_access_arb #(
  parameter int SET_W      = 7,
  parameter int TAG_W      = 35,
  parameter int STATE_W    = 3,
  parameter int NUM_RN     = 4,
  parameter int ID_W       = 4,
  parameter int STARVE_MAX = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               lkp_valid,
  output logic               lkp_ready,
  input  logic [SET_W-1:0]   lkp_set,
  input  logic [TAG_W-1:0]   lkp_tag,
  input  logic [ID_W-1:0]    lkp_id,
  input  logic               upd_valid,
  output logic               upd_ready,
  input  logic [SET_W-1:0]   upd_set,
  input  logic [TAG_W-1:0]   upd_tag,
  input  logic [STATE_W-1:0] upd_state,
  input  logic [NUM_RN-1:0]  upd_vec,
  output logic               arr_rd_en,
  output logic [SET_W-1:0]   arr_rd_set,
  input  logic [TAG_W-1:0]   arr_rd_tag,
  input  logic [STATE_W-1:0] arr_rd_state,
  input  logic [NUM_RN-1:0]  arr_rd_vec,
  output logic               arr_wr_en,
  output logic [SET_W-1:0]   arr_wr_set,
  output logic [TAG_W-1:0]   arr_wr_tag,
  output logic [STATE_W-1:0] arr_wr_state,
  output logic [NUM_RN-1:0]  arr_wr_vec,
  output logic               res_valid,
  input  logic               res_ready,
  output logic               res_hit,
  output logic [STATE_W-1:0] res_state,
  output logic [NUM_RN-1:0]  res_vec,
  output logic [ID_W-1:0]    res_id
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic [2:0] {IDLE, RD, CMP, RSP, WR} state_t;

  state_t           state, next_state;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             grant_upd, grant_lkp;
  logic             rd_hit;
  logic [TAG_W-1:0] lkp_tag_q;
  logic [ID_W-1:0]  lkp_id_q;

  assign starved   = (starve_cnt == CNT_W'(STARVE_MAX));
  assign rd_hit    = (arr_rd_tag == lkp_tag_q) && (arr_rd_state != '0);
  assign upd_ready = grant_upd;
  assign lkp_ready = grant_lkp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Grants are gated by rst so the ready outputs also read 0 while reset is held.
  always_comb begin
    next_state = state;
    grant_upd  = 1'b0;
    grant_lkp  = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rst) begin
          if (upd_valid && !(lkp_valid && starved)) begin
            grant_upd  = 1'b1;
            next_state = WR;
          end else if (lkp_valid) begin
            grant_lkp  = 1'b1;
            next_state = RD;
          end
        end
      end
      RD:      next_state = CMP;
      CMP:     next_state = RSP;
      RSP:     if (res_ready) next_state = IDLE;
      WR:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt   <= '0;
      arr_rd_en    <= 1'b0;
      arr_rd_set   <= '0;
      lkp_tag_q    <= '0;
      lkp_id_q     <= '0;
      arr_wr_en    <= 1'b0;
      arr_wr_set   <= '0;
      arr_wr_tag   <= '0;
      arr_wr_state <= '0;
      arr_wr_vec   <= '0;
      res_valid    <= 1'b0;
      res_hit      <= 1'b0;
      res_state    <= '0;
      res_vec      <= '0;
      res_id       <= '0;
    end else begin
      if (grant_lkp)
        starve_cnt <= '0;
      else if (grant_upd && lkp_valid && !starved)
        starve_cnt <= starve_cnt + CNT_W'(1);

      arr_rd_en <= grant_lkp;
      if (grant_lkp) begin
        arr_rd_set <= lkp_set;
        lkp_tag_q  <= lkp_tag;
        lkp_id_q   <= lkp_id;
      end

      arr_wr_en <= grant_upd;
      if (grant_upd) begin
        arr_wr_set   <= upd_set;
        arr_wr_tag   <= upd_tag;
        arr_wr_state <= upd_state;
        arr_wr_vec   <= upd_vec;
      end

      if (state == CMP) begin
        res_valid <= 1'b1;
        res_hit   <= rd_hit;
        res_state <= rd_hit ? arr_rd_state : '0;
        res_vec   <= rd_hit ? arr_rd_vec : '0;
        res_id    <= lkp_id_q;
      end else if (state == RSP && res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sf_access_arb.sv
// Self-checking bench for sf_access_arb: directed vector table, multi-cycle corner
// sequences, and randomized traffic against a reference model of SF array contents.
module tb_sf_access_arb;

  localparam int SET_W      = 7;
  localparam int TAG_W      = 35;
  localparam int STATE_W    = 3;
  localparam int NUM_RN     = 4;
  localparam int ID_W       = 4;
  localparam int STARVE_MAX = 4;
  localparam int NSETS      = 1 << SET_W;
  localparam int TMO        = 40;

  logic               clk, rst;
  logic               lkp_valid, lkp_ready;
  logic [SET_W-1:0]   lkp_set;
  logic [TAG_W-1:0]   lkp_tag;
  logic [ID_W-1:0]    lkp_id;
  logic               upd_valid, upd_ready;
  logic [SET_W-1:0]   upd_set;
  logic [TAG_W-1:0]   upd_tag;
  logic [STATE_W-1:0] upd_state;
  logic [NUM_RN-1:0]  upd_vec;
  logic               arr_rd_en;
  logic [SET_W-1:0]   arr_rd_set;
  logic [TAG_W-1:0]   arr_rd_tag;
  logic [STATE_W-1:0] arr_rd_state;
  logic [NUM_RN-1:0]  arr_rd_vec;
  logic               arr_wr_en;
  logic [SET_W-1:0]   arr_wr_set;
  logic [TAG_W-1:0]   arr_wr_tag;
  logic [STATE_W-1:0] arr_wr_state;
  logic [NUM_RN-1:0]  arr_wr_vec;
  logic               res_valid, res_ready, res_hit;
  logic [STATE_W-1:0] res_state;
  logic [NUM_RN-1:0]  res_vec;
  logic [ID_W-1:0]    res_id;

  sf_access_arb #(
    .SET_W(SET_W), .TAG_W(TAG_W), .STATE_W(STATE_W),
    .NUM_RN(NUM_RN), .ID_W(ID_W), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .lkp_valid(lkp_valid), .lkp_ready(lkp_ready), .lkp_set(lkp_set),
    .lkp_tag(lkp_tag), .lkp_id(lkp_id),
    .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_set(upd_set),
    .upd_tag(upd_tag), .upd_state(upd_state), .upd_vec(upd_vec),
    .arr_rd_en(arr_rd_en), .arr_rd_set(arr_rd_set), .arr_rd_tag(arr_rd_tag),
    .arr_rd_state(arr_rd_state), .arr_rd_vec(arr_rd_vec),
    .arr_wr_en(arr_wr_en), .arr_wr_set(arr_wr_set), .arr_wr_tag(arr_wr_tag),
    .arr_wr_state(arr_wr_state), .arr_wr_vec(arr_wr_vec),
    .res_valid(res_valid), .res_ready(res_ready), .res_hit(res_hit),
    .res_state(res_state), .res_vec(res_vec), .res_id(res_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Single-ported array behind the DUT; read data is junk except the cycle after a read.
  logic [TAG_W-1:0]   mem_tag   [NSETS];
  logic [STATE_W-1:0] mem_state [NSETS];
  logic [NUM_RN-1:0]  mem_vec   [NSETS];

  always @(posedge clk) begin
    if (arr_wr_en) begin
      mem_tag[arr_wr_set]   <= arr_wr_tag;
      mem_state[arr_wr_set] <= arr_wr_state;
      mem_vec[arr_wr_set]   <= arr_wr_vec;
    end
    if (arr_rd_en) begin
      arr_rd_tag   <= mem_tag[arr_rd_set];
      arr_rd_state <= mem_state[arr_rd_set];
      arr_rd_vec   <= mem_vec[arr_rd_set];
    end else begin
      arr_rd_tag   <= TAG_W'({$urandom, $urandom});
      arr_rd_state <= STATE_W'($urandom);
      arr_rd_vec   <= NUM_RN'($urandom);
    end
  end

  // Reference model: SF contents as seen in grant order, plus expected result queue.
  typedef struct packed {
    logic               hit;
    logic [STATE_W-1:0] st;
    logic [NUM_RN-1:0]  vec;
    logic [ID_W-1:0]    id;
  } res_t;

  logic [TAG_W-1:0]   ref_tag   [NSETS];
  logic [STATE_W-1:0] ref_state [NSETS];
  logic [NUM_RN-1:0]  ref_vec   [NSETS];
  res_t               exp_q[$];
  int                 upd_streak = 0;

  initial begin
    for (int unsigned i = 0; i < NSETS; i++) begin
      mem_tag[i] = '0; mem_state[i] = '0; mem_vec[i] = '0;
      ref_tag[i] = '0; ref_state[i] = '0; ref_vec[i] = '0;
    end
  end

  always @(negedge clk) begin
    #2;
    if (rst) begin
      exp_q.delete();
      upd_streak = 0;
    end else begin
      chk("strobe_excl", 64'(arr_rd_en & arr_wr_en), 64'(0));
      chk("ready_excl", 64'(upd_ready & lkp_ready), 64'(0));
      if (upd_valid && upd_ready) begin
        ref_tag[upd_set]   = upd_tag;
        ref_state[upd_set] = upd_state;
        ref_vec[upd_set]   = upd_vec;
        if (lkp_valid) begin
          upd_streak++;
          chk("starve_bound", 64'(upd_streak <= STARVE_MAX), 64'(1));
        end
      end
      if (lkp_valid && lkp_ready) begin
        res_t e;
        if (upd_valid) chk("starve_turn", 64'(upd_streak), 64'(STARVE_MAX));
        upd_streak = 0;
        e.hit = (ref_tag[lkp_set] == lkp_tag) && (ref_state[lkp_set] != 0);
        e.st  = e.hit ? ref_state[lkp_set] : '0;
        e.vec = e.hit ? ref_vec[lkp_set] : '0;
        e.id  = lkp_id;
        exp_q.push_back(e);
      end
      if (res_valid && res_ready) begin
        chk("res_pending", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          res_t e;
          e = exp_q.pop_front();
          chk("model_result", 64'({res_hit, res_state, res_vec, res_id}), 64'(e));
        end
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({lkp_ready, upd_ready, arr_rd_en, arr_wr_en, res_valid, res_hit}), 64'(0));
    chk({tag, "_arr"}, 64'({arr_rd_set, arr_wr_set, arr_wr_tag, arr_wr_state, arr_wr_vec}), 64'(0));
    chk({tag, "_res"}, 64'({res_state, res_vec, res_id}), 64'(0));
  endtask

  task automatic do_upd(input logic [SET_W-1:0] s, input logic [TAG_W-1:0] t,
                        input logic [STATE_W-1:0] st, input logic [NUM_RN-1:0] v);
    int n = 0;
    @(negedge clk);
    upd_valid = 1'b1; upd_set = s; upd_tag = t; upd_state = st; upd_vec = v;
    #1;
    while (!upd_ready && n < TMO) begin @(negedge clk); #1; n++; end
    chk("upd_accept_timeout", 64'(n < TMO), 64'(1));
    @(negedge clk);
    upd_valid = 1'b0;
    #1;
    chk("wr_en_pulse", 64'(arr_wr_en), 64'(1));
    chk("wr_fields", 64'({arr_wr_set, arr_wr_tag, arr_wr_state, arr_wr_vec}), 64'({s, t, st, v}));
    @(negedge clk); #1;
    chk("wr_en_single", 64'(arr_wr_en), 64'(0));
  endtask

  task automatic do_lkp(input logic [SET_W-1:0] s, input logic [TAG_W-1:0] t,
                        input logic [ID_W-1:0] id, input logic eh,
                        input logic [STATE_W-1:0] est, input logic [NUM_RN-1:0] ev);
    int n = 0;
    bit got = 0;
    @(negedge clk);
    lkp_valid = 1'b1; lkp_set = s; lkp_tag = t; lkp_id = id; res_ready = 1'b0;
    #1;
    while (!lkp_ready && n < TMO) begin @(negedge clk); #1; n++; end
    chk("lkp_accept_timeout", 64'(n < TMO), 64'(1));
    n = 0;
    while (!got && n < TMO) begin
      @(negedge clk);
      lkp_valid = 1'b0;
      #1; n++;
      if (n == 1) begin
        chk("rd_en", 64'(arr_rd_en), 64'(1));
        chk("rd_set", 64'(arr_rd_set), 64'(s));
      end
      if (res_valid) got = 1;
    end
    chk("res_latency", 64'(n), 64'(3));
    chk("tbl_result", 64'({res_hit, res_state, res_vec, res_id}), 64'({eh, est, ev, id}));
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    #1;
    chk("res_drop", 64'(res_valid), 64'(0));
  endtask

  typedef struct {
    bit                 is_upd;
    logic [SET_W-1:0]   set;
    logic [TAG_W-1:0]   tag;
    logic [STATE_W-1:0] st;
    logic [NUM_RN-1:0]  vec;
    logic [ID_W-1:0]    id;
    logic               e_hit;
    logic [STATE_W-1:0] e_st;
    logic [NUM_RN-1:0]  e_vec;
  } vec_t;

  function automatic vec_t mk(bit u, int s, logic [TAG_W-1:0] t, int st, int v, int id,
                              bit h, int est, int ev);
    vec_t r;
    r.is_upd = u; r.set = SET_W'(s); r.tag = t; r.st = STATE_W'(st);
    r.vec = NUM_RN'(v); r.id = ID_W'(id); r.e_hit = h;
    r.e_st = STATE_W'(est); r.e_vec = NUM_RN'(ev);
    return r;
  endfunction

  vec_t tbl[13];
  logic [TAG_W-1:0] top_tag;
  logic [63:0]      snap;
  int               seq[10];
  bit               u_acc, l_acc;

  initial begin
    rst = 1'b1; lkp_valid = 1'b0; upd_valid = 1'b0; res_ready = 1'b0;
    lkp_set = '0; lkp_tag = '0; lkp_id = '0;
    upd_set = '0; upd_tag = '0; upd_state = '0; upd_vec = '0;
    top_tag = '1;

    tbl[0]  = mk(1,   5, 35'h1234,      2, 4'b0011,  0, 0, 0, 0);
    tbl[1]  = mk(0,   5, 35'h1234,      0, 0,        3, 1, 2, 4'b0011);
    tbl[2]  = mk(1,   9, 35'h1,         0, 4'hF,     0, 0, 0, 0);
    tbl[3]  = mk(0,   9, 35'h1,         0, 0,        5, 0, 0, 0);
    tbl[4]  = mk(1,   9, 35'h2,         1, 4'h1,     0, 0, 0, 0);
    tbl[5]  = mk(0,   9, 35'h3,         0, 0,        6, 0, 0, 0);
    tbl[6]  = mk(0,   9, 35'h2,         0, 0,        7, 1, 1, 4'h1);
    tbl[7]  = mk(0,   5, 35'h400001234, 0, 0,        8, 0, 0, 0);
    tbl[8]  = mk(1, 127, top_tag,       7, 4'hF,     0, 0, 0, 0);
    tbl[9]  = mk(0, 127, top_tag,       0, 0,       15, 1, 7, 4'hF);
    tbl[10] = mk(0,   0, 35'h0,         0, 0,        0, 0, 0, 0);
    tbl[11] = mk(1,   5, 35'h1234,      4, 4'h8,     0, 0, 0, 0);
    tbl[12] = mk(0,   5, 35'h1234,      0, 0,        1, 1, 4, 4'h8);

    #3;
    lkp_valid = 1'b1; upd_valid = 1'b1;
    #1;
    chk_all_zero("reset_state");
    lkp_valid = 1'b0; upd_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      chk("idle_no_strobe", 64'({arr_rd_en, arr_wr_en, res_valid}), 64'(0));
    end

    for (int i = 0; i < 13; i++) begin
      if (tbl[i].is_upd) do_upd(tbl[i].set, tbl[i].tag, tbl[i].st, tbl[i].vec);
      else do_lkp(tbl[i].set, tbl[i].tag, tbl[i].id, tbl[i].e_hit, tbl[i].e_st, tbl[i].e_vec);
    end

    // Reset asserted while the lookup sits in RD.
    begin
      int n = 0;
      @(negedge clk);
      lkp_valid = 1'b1; lkp_set = 7'd5; lkp_tag = 35'h1234; lkp_id = 4'd2;
      #1;
      while (!lkp_ready && n < TMO) begin @(negedge clk); #1; n++; end
      chk("rst_lkp_timeout", 64'(n < TMO), 64'(1));
      @(negedge clk); #1;
      chk("rst_in_rd", 64'(arr_rd_en), 64'(1));
      upd_valid = 1'b1;
      rst = 1'b1;
      #1;
      chk_all_zero("reset_mid_rd");
      @(negedge clk);
      rst = 1'b0; lkp_valid = 1'b0; upd_valid = 1'b0;
      repeat (5) begin
        @(negedge clk); #1;
        chk("post_rst_quiet", 64'({arr_rd_en, arr_wr_en, res_valid}), 64'(0));
      end
    end

    // Both requesters always valid: four updates then one lookup, repeating.
    begin
      int g = 0;
      int n = 0;
      @(negedge clk);
      upd_valid = 1'b1; upd_set = 7'd20; upd_tag = 35'h77; upd_state = 3'd3; upd_vec = 4'h5;
      lkp_valid = 1'b1; lkp_set = 7'd20; lkp_tag = 35'h77; lkp_id = 4'd4;
      res_ready = 1'b1;
      while (g < 10 && n < 200) begin
        #1;
        if (upd_ready) begin seq[g] = 0; g++; end
        else if (lkp_ready) begin seq[g] = 1; g++; end
        n++;
        @(negedge clk);
      end
      chk("simul_timeout", 64'(g), 64'(10));
      for (int i = 0; i < 10; i++)
        chk($sformatf("simul_grant_%0d", i), 64'(seq[i]), 64'((i % 5 == 4) ? 1 : 0));
      upd_valid = 1'b0; lkp_valid = 1'b0;
      repeat (8) @(negedge clk);
      res_ready = 1'b0;
    end

    // Result back-pressure: res held, updates stall until the result handshake.
    begin
      int n = 0;
      lkp_valid = 1'b1; lkp_set = 7'd5; lkp_tag = 35'h1234; lkp_id = 4'd9;
      #1;
      while (!lkp_ready && n < TMO) begin @(negedge clk); #1; n++; end
      chk("bp_accept_timeout", 64'(n < TMO), 64'(1));
      n = 0;
      @(negedge clk);
      lkp_valid = 1'b0;
      #1;
      while (!res_valid && n < TMO) begin @(negedge clk); #1; n++; end
      chk("bp_res_timeout", 64'(n < TMO), 64'(1));
      snap = 64'({res_hit, res_state, res_vec, res_id});
      chk("bp_result", snap, 64'({1'b1, 3'd4, 4'h8, 4'd9}));
      upd_valid = 1'b1; upd_set = 7'd30; upd_tag = 35'hABC; upd_state = 3'd5; upd_vec = 4'hA;
      #1;
      for (int i = 0; i < 10; i++) begin
        chk("bp_upd_stall", 64'(upd_ready), 64'(0));
        chk("bp_res_stable", 64'({res_valid, res_hit, res_state, res_vec, res_id}), {51'b0, 1'b1, snap[11:0]});
        @(negedge clk); #1;
      end
      res_ready = 1'b1;
      #1;
      chk("bp_upd_stall_hs", 64'(upd_ready), 64'(0));
      @(negedge clk);
      res_ready = 1'b0;
      #1;
      chk("bp_res_dropped", 64'(res_valid), 64'(0));
      chk("bp_upd_granted", 64'(upd_ready), 64'(1));
      @(negedge clk);
      upd_valid = 1'b0;
      #1;
      chk("bp_wr", 64'({arr_wr_en, arr_wr_set}), 64'({1'b1, 7'd30}));
    end

    // Randomized mixed traffic over a few sets and a small tag pool.
    u_acc = 1'b0; l_acc = 1'b0;
    for (int c = 0; c < 800; c++) begin
      @(negedge clk);
      if (!upd_valid || u_acc) begin
        upd_valid = ($urandom_range(0, 2) == 0);
        upd_set   = SET_W'($urandom_range(0, 7));
        upd_tag   = TAG_W'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) upd_tag[TAG_W-1] = 1'b1;
        upd_state = STATE_W'($urandom);
        upd_vec   = NUM_RN'($urandom);
      end
      if (!lkp_valid || l_acc) begin
        lkp_valid = ($urandom_range(0, 1) == 0);
        lkp_set   = SET_W'($urandom_range(0, 7));
        lkp_tag   = TAG_W'($urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) lkp_tag[TAG_W-1] = 1'b1;
        lkp_id    = ID_W'($urandom);
      end
      res_ready = ($urandom_range(0, 2) != 0);
      #1;
      u_acc = upd_valid && upd_ready;
      l_acc = lkp_valid && lkp_ready;
    end
    @(negedge clk);
    upd_valid = 1'b0; lkp_valid = 1'b0; res_ready = 1'b1;
    repeat (10) @(negedge clk);
    #3;
    chk("drain_empty", 64'(exp_q.size()), 64'(0));

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
